// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit.
package hazard_pkg;

  // Operand source selects for the forwarding muxes
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // Multi-cycle divider occupancy state
  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } divState_t;

endpackage

// File: rtl/hazard_ctrl_div_stall_fsm.sv
// Divider occupancy tracker: holds BUSY for DIV_LAT cycles after a start.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic abort,
  output logic busy
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  divState_t     state;
  logic [CW-1:0] cnt;

  // State, countdown and registered busy flag; abort drops BUSY on the next edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state <= DIV_BUSY;
            cnt   <= CW'(DIV_LAT - 1);
            busy  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          // a second start while busy is deliberately ignored
          if (abort || cnt == '0) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= DIV_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use / branch stalls,
// divider occupancy stalls, exception flushes and a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 32,
  parameter int BR_IN_D = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              divstartE,
  input  logic              branchtakenE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              hilowriteM,
  input  logic              exceptM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              hilowriteW,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic [1:0]        forwardhiloE,
  output logic              divbusy,
  output logic [CNT_W-1:0]  stallcnt
);

  localparam bit BR_D = (BR_IN_D != 0);

  // M beats W; register 0 is hardwired and never forwarded
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                        input logic [REG_AW-1:0] wrM, input logic weM,
                                        input logic [REG_AW-1:0] wrW, input logic weW);
    if (src == '0)              return FWD_NONE;
    if (weM && src == wrM)      return FWD_M;
    if (weW && src == wrW)      return FWD_W;
    return FWD_NONE;
  endfunction

  logic lwStall, brStall, hazStall, brTakenE;

  div_stall_fsm #(.DIV_LAT(DIV_LAT)) uDiv (
    .clk    (clk),
    .resetn (resetn),
    .start  (divstartE && !exceptM),
    .abort  (exceptM),
    .busy   (divbusy)
  );

  // Hazard detection and the stall/flush/forward decisions
  always_comb begin
    lwStall  = memtoregE && (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
    brStall  = BR_D && branchD &&
               ((regwriteE && (writeregE != '0) && (writeregE == rsD || writeregE == rtD)) ||
                (memtoregM && (writeregM != '0) && (writeregM == rsD || writeregM == rtD)));
    brTakenE = !BR_D && branchtakenE;
    // a taken E-branch squashes D anyway, so holding F/D for it is pointless
    hazStall = (lwStall || brStall) && !brTakenE;

    forwardaE    = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE    = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardhiloE = hilowriteM ? FWD_M : (hilowriteW ? FWD_W : FWD_NONE);
    forwardaD    = BR_D && (fwdSel(rsD, writeregM, regwriteM, writeregW, 1'b0) == FWD_M);
    forwardbD    = BR_D && (fwdSel(rtD, writeregM, regwriteM, writeregW, 1'b0) == FWD_M);

    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallF = hazStall || divbusy;
      stallD = hazStall || divbusy;
      stallE = divbusy;
      flushD = brTakenE;
      // E is frozen while the divider runs, so no bubble is inserted there
      flushE = (lwStall || brStall) && !divbusy;
      flushM = divbusy;
    end
  end

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          stallcnt <= '0;
    else if (stallF && stallcnt != '1)    stallcnt <= stallcnt + 1'b1;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter DIV_LAT, default 32: multi-cycle divider latency in cycles, minimum 2.
REQ-003 SHALL have parameter BR_IN_D, default 1: 1 = branches resolve in D; 0 = branches resolve in E.
REQ-004 SHALL have parameter CNT_W, default 32: stall-counter width.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports rsD, rtD, input, REG_AW each: D-stage source registers.
REQ-008 SHALL have port branchD, input, 1: D-stage conditional branch.
REQ-009 SHALL have ports rsE, rtE, writeregE, input, REG_AW each: E-stage sources and destination.
REQ-010 SHALL have ports regwriteE, memtoregE, divstartE, input, 1 each: E-stage writes reg / is load / starts divide.
REQ-011 SHALL have port branchtakenE, input, 1: E-resolved taken branch; used only when BR_IN_D=0.
REQ-012 SHALL have ports writeregM (REG_AW), regwriteM, memtoregM, hilowriteM, exceptM, input: M-stage status.
REQ-013 SHALL have ports writeregW (REG_AW), regwriteW, hilowriteW, input: W-stage status.
REQ-014 SHALL have ports stallF, stallD, stallE, output, 1 each: active-high stage holds.
REQ-015 SHALL have ports flushD, flushE, flushM, flushW, output, 1 each: active-high bubble inserts.
REQ-016 SHALL have ports forwardaD, forwardbD, output, 1 each: D-stage forward from M.
REQ-017 SHALL have ports forwardaE, forwardbE, forwardhiloE, output, 2 each: E-stage operand and HI/LO source select.
REQ-018 SHALL have ports divbusy (1) and stallcnt (CNT_W), output: divider busy flag and stall-cycle count.

Function
REQ-019 Forward encodings SHALL be 00 register file, 01 from W, 10 from M; M match SHALL win over W match; register 0 SHALL never forward.
REQ-020 forwardaE SHALL be 10 when rsE==writeregM and regwriteM; otherwise 01 when rsE==writeregW and regwriteW; otherwise 00. forwardbE SHALL use rtE with the same rule.
REQ-021 forwardhiloE SHALL be 10 when hilowriteM, 01 when only hilowriteW, and 00 otherwise.
REQ-022 forwardaD/forwardbD SHALL follow the REQ-020 M-stage rule using rsD/rtD when BR_IN_D=1, and SHALL be constant 0 when BR_IN_D=0.
REQ-023 lwstall SHALL be memtoregE and writeregE!=0 and (writeregE==rsD or writeregE==rtD).
REQ-024 brstall (BR_IN_D=1 only) SHALL be branchD and ((regwriteE and writeregE!=0 and writeregE in {rsD,rtD}) or (memtoregM and writeregM!=0 and writeregM in {rsD,rtD})).
REQ-025 On lwstall or brstall: stallF=stallD=1 and flushE=1.
REQ-026 When BR_IN_D=0 and branchtakenE: flushD=1, and stallF/stallD SHALL be suppressed in that cycle.
REQ-027 Divider FSM states SHALL be IDLE and BUSY. IDLE->BUSY on divstartE with exceptM=0, loading the counter to DIV_LAT-1. In BUSY the counter SHALL decrement each cycle; BUSY->IDLE on the cycle the counter reads 0.
REQ-028 While BUSY: divbusy=1, stallF=stallD=stallE=1, flushM=1. divstartE received in BUSY SHALL be ignored.
REQ-029 exceptM SHALL force flushD=flushE=flushM=flushW=1 and all stalls to 0 in the same cycle, overriding REQ-025 to REQ-028; a BUSY FSM SHALL return to IDLE on the next edge.
REQ-030 stallcnt SHALL increment on each edge where stallF=1 and SHALL saturate at all-ones.
REQ-031 All outputs other than divbusy and stallcnt SHALL be combinational from inputs and the FSM state; divbusy SHALL be registered state.

Reset
REQ-032 resetn low SHALL immediately force state IDLE, counter 0, stallcnt 0, divbusy 0; with idle inputs, all stall and flush outputs SHALL read 0.

Structure
REQ-033 Package hazard_pkg SHALL hold the FWD_NONE/FWD_W/FWD_M encodings and the divider state type.
REQ-034 The divider FSM and counter SHALL be the sub-module div_stall_fsm; forwarding and stall logic SHALL stay in hazard_ctrl.

Verification
REQ-035 Forward priority: rsE=rtE=3, writeregM=writeregW=3, both regwrite=1 -> forwardaE=forwardbE=10; with regwriteM=0 -> 01; with rsE=0 -> 00.
REQ-036 Load-use: memtoregE=1, writeregE=5, rtD=5 -> stallF=stallD=flushE=1 for 1 cycle; with writeregE=0 -> no stall.
REQ-037 Divider: DIV_LAT=4, divstartE pulse -> divbusy and stallE high for exactly 4 cycles, then low; stallcnt advances by 4.
REQ-038 Exception mid-divide: exceptM on the 2nd BUSY cycle -> all four flushes=1 and stalls=0 that cycle; divbusy=0 after the next edge.
REQ-039 Mode and reset: BR_IN_D=0 with branchtakenE -> flushD=1, forwardaD=0; resetn low mid-BUSY -> divbusy=0 and stallcnt=0 asynchronously.
